// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: groups the hazard/EX inputs, the imem handshake and the
// PC-update controls exchanged between fetch_ctrl and the IF stage.
// Ports (master = fetch_ctrl side):
//   stall, redirectValid, redirectPc, imemReady            -> into fetch_ctrl
//   imemReq, pcEn, branchSel, branchVal, ifValid, flush,
//   fetchErr                                               -> out of fetch_ctrl
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirectValid;
  logic [XLEN-1:0] redirectPc;
  logic            imemReady;
  logic            imemReq;
  logic            pcEn;
  logic            branchSel;
  logic [XLEN-1:0] branchVal;
  logic            ifValid;
  logic            flush;
  logic            fetchErr;

  modport master (
    input  stall, redirectValid, redirectPc, imemReady,
    output imemReq, pcEn, branchSel, branchVal, ifValid, flush, fetchErr
  );

  modport slave (
    output stall, redirectValid, redirectPc, imemReady,
    input  imemReq, pcEn, branchSel, branchVal, ifValid, flush, fetchErr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer. Waits RST_HOLD cycles after reset, then
// issues instruction-memory requests, tolerating wait-states, applying EX
// redirects (immediately or once the in-flight access completes), holding
// the fetched word during hazard stalls and raising a sticky fetchErr when a
// request waits MAX_WAIT cycles.
// Ports:
//   clk     rising-edge clock
//   pcRstN  asynchronous active-low reset
//   bus     fetch_ctrl_if.master (hazard/EX inputs, imem handshake, PC controls)
module fetch_ctrl #(
  parameter int XLEN     = 32,
  parameter int RST_HOLD = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic         clk,
  input  logic         pcRstN,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [3:0]      HOLD_LAST  = 4'(RST_HOLD - 1);
  localparam logic [7:0]      WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state, state_nxt;
  logic [3:0]      hold_cnt, hold_cnt_nxt;
  logic [7:0]      wait_cnt, wait_cnt_nxt;
  logic            pend, pend_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic [XLEN-1:0] bval_q;
  logic [XLEN-1:0] target;

  logic imem_req, pc_en, branch_sel, if_valid, flush_o, fetch_err;
  logic [XLEN-1:0] branch_val;

  // State, counters, pending redirect and last branch target.
  always_ff @(posedge clk or negedge pcRstN) begin
    if (!pcRstN) begin
      state    <= HOLD;
      hold_cnt <= '0;
      wait_cnt <= '0;
      pend     <= 1'b0;
      pend_pc  <= '0;
      bval_q   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      pend     <= pend_nxt;
      pend_pc  <= pend_pc_nxt;
      if (branch_sel) begin
        bval_q <= branch_val;
      end
    end
  end

  // Next-state and output decode. A redirect always beats a stall; a
  // redirect arriving while the imem access is outstanding is parked in
  // pend/pend_pc so the in-flight word is never torn.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    wait_cnt_nxt = wait_cnt;
    pend_nxt     = pend;
    pend_pc_nxt  = pend_pc;
    target       = '0;
    imem_req     = 1'b0;
    pc_en        = 1'b0;
    branch_sel   = 1'b0;
    if_valid     = 1'b0;
    flush_o      = 1'b0;
    fetch_err    = 1'b0;

    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = REQ;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 4'd1;
        end
        if (bus.redirectValid) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = bus.redirectPc;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (bus.imemReady) begin
          wait_cnt_nxt = '0;
          if (bus.redirectValid || pend) begin
            flush_o    = 1'b1;
            pc_en      = 1'b1;
            branch_sel = 1'b1;
            target     = bus.redirectValid ? bus.redirectPc : pend_pc;
            pend_nxt   = 1'b0;
          end else if (bus.stall) begin
            if_valid  = 1'b1;
            state_nxt = STALL;
          end else begin
            if_valid = 1'b1;
            pc_en    = 1'b1;
          end
        end else begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
          if (bus.redirectValid) begin
            pend_nxt    = 1'b1;
            pend_pc_nxt = bus.redirectPc;
          end
        end
      end

      STALL: begin
        if (bus.redirectValid) begin
          flush_o    = 1'b1;
          pc_en      = 1'b1;
          branch_sel = 1'b1;
          target     = bus.redirectPc;
          state_nxt  = REQ;
        end else begin
          if_valid = 1'b1;
          if (!bus.stall) begin
            pc_en     = 1'b1;
            state_nxt = REQ;
          end
        end
      end

      ERR: begin
        fetch_err = 1'b1;
      end

      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

  // branchVal shows the new target in the redirect cycle, otherwise the
  // last target taken; forced to zero while in ERR.
  always_comb begin
    if (state == ERR) begin
      branch_val = '0;
    end else if (branch_sel) begin
      branch_val = target & ALIGN_MASK;
    end else begin
      branch_val = bval_q;
    end
  end

  assign bus.imemReq   = imem_req;
  assign bus.pcEn      = pc_en;
  assign bus.branchSel = branch_sel;
  assign bus.branchVal = branch_val;
  assign bus.ifValid   = if_valid;
  assign bus.flush     = flush_o;
  assign bus.fetchErr  = fetch_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the fetch sequencer.
module tb_fetch_ctrl;
  localparam int XLEN     = 32;
  localparam int RST_HOLD = 4;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic pcRstN;
  int   checks = 0;
  int   errors = 0;

  fetch_ctrl_if #(.XLEN(XLEN)) bus ();

  fetch_ctrl #(
    .XLEN(XLEN), .RST_HOLD(RST_HOLD), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .pcRstN(pcRstN), .bus(bus)
  );

  always #5 clk = ~clk;

  // Flags in order {imemReq, pcEn, branchSel, ifValid, flush, fetchErr}
  function automatic logic [5:0] flags();
    return {bus.imemReq, bus.pcEn, bus.branchSel, bus.ifValid, bus.flush, bus.fetchErr};
  endfunction

  task automatic set_idle();
    bus.stall = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc = '0;
    bus.imemReady = 1'b0;
  endtask

  // Resets, waits out the hold period, returns at a negedge in the fetch state.
  task automatic do_reset(input logic ready);
    @(negedge clk);
    pcRstN = 1'b0;
    set_idle();
    bus.imemReady = ready;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pcRstN = 1'b1;
    repeat (RST_HOLD) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    pcRstN = 1'b0;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'hDEAD_BEEF;
    bus.imemReady = 1'b1;
    bus.stall = 1'b1;
    #1;
    checks++;
    if (flags() !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected %b", flags(), 6'b0); end
    checks++;
    if (bus.branchVal !== 32'h0) begin errors++; $display("[TB] FAIL reset_bval: got %h expected %h", bus.branchVal, 32'h0); end
    @(negedge clk);
    pcRstN = 1'b1;
    #1;
    checks++;
    if (flags() !== 6'b0) begin errors++; $display("[TB] FAIL hold_flags: got %b expected %b", flags(), 6'b0); end
  endtask

  task automatic test_startup();
    @(negedge clk);
    pcRstN = 1'b0;
    set_idle();
    bus.imemReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pcRstN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.imemReq !== (k >= RST_HOLD)) begin
        errors++; $display("[TB] FAIL startup_req[%0d]: got %b expected %b", k, bus.imemReq, (k >= RST_HOLD));
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.pcEn, bus.ifValid, bus.branchSel} !== 3'b110) begin
        errors++; $display("[TB] FAIL startup_stream[%0d]: got %b expected %b", k, {bus.pcEn, bus.ifValid, bus.branchSel}, 3'b110);
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      bus.imemReady = (i % 3 == 2);
      #1;
      checks++;
      if (bus.pcEn !== bus.imemReady || bus.ifValid !== bus.imemReady) begin
        errors++; $display("[TB] FAIL wait_pcen[%0d]: got pcEn=%b ifValid=%b expected %b", i, bus.pcEn, bus.ifValid, (i % 3 == 2));
      end
      checks++;
      if (bus.fetchErr !== 1'b0) begin errors++; $display("[TB] FAIL wait_err[%0d]: got %b expected 0", i, bus.fetchErr); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0);
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'd40;
    #1;
    checks++;
    if ({bus.pcEn, bus.flush} !== 2'b00) begin errors++; $display("[TB] FAIL redir_wait0: got %b expected 00", {bus.pcEn, bus.flush}); end
    @(negedge clk);
    bus.redirectValid = 1'b0;
    #1;
    checks++;
    if ({bus.pcEn, bus.flush} !== 2'b00) begin errors++; $display("[TB] FAIL redir_wait1: got %b expected 00", {bus.pcEn, bus.flush}); end
    @(negedge clk);
    bus.imemReady = 1'b1;
    #1;
    checks++;
    if ({bus.pcEn, bus.branchSel, bus.flush, bus.ifValid} !== 4'b1110 || bus.branchVal !== 32'd40) begin
      errors++; $display("[TB] FAIL redir_apply: got %b/%0d expected 1110/40", {bus.pcEn, bus.branchSel, bus.flush, bus.ifValid}, bus.branchVal);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.pcEn, bus.branchSel, bus.flush} !== 3'b100 || bus.branchVal !== 32'd40) begin
      errors++; $display("[TB] FAIL redir_keep: got %b/%0d expected 100/40", {bus.pcEn, bus.branchSel, bus.flush}, bus.branchVal);
    end
    // Two redirects during one wait: the newer target wins.
    @(negedge clk);
    bus.imemReady = 1'b0;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h80;
    @(negedge clk);
    bus.redirectPc = 32'h88;
    @(negedge clk);
    bus.redirectValid = 1'b0;
    bus.imemReady = 1'b1;
    #1;
    checks++;
    if (bus.branchVal !== 32'h88 || bus.flush !== 1'b1) begin
      errors++; $display("[TB] FAIL redir_newest: got %h/%b expected 88/1", bus.branchVal, bus.flush);
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    bus.stall = 1'b1;
    #1;
    checks++;
    if ({bus.ifValid, bus.pcEn} !== 2'b10) begin errors++; $display("[TB] FAIL stall_enter: got %b expected 10", {bus.ifValid, bus.pcEn}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.imemReady = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({bus.ifValid, bus.pcEn, bus.imemReq} !== 3'b100) begin
        errors++; $display("[TB] FAIL stall_hold[%0d]: got %b expected 100", i, {bus.ifValid, bus.pcEn, bus.imemReq});
      end
    end
    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    checks++;
    if ({bus.pcEn, bus.branchSel} !== 2'b10) begin errors++; $display("[TB] FAIL stall_release: got %b expected 10", {bus.pcEn, bus.branchSel}); end
    @(negedge clk);
    bus.imemReady = 1'b0;
    #1;
    checks++;
    if (bus.imemReq !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume: got %b expected 1", bus.imemReq); end
  endtask

  task automatic test_stall_redirect();
    do_reset(1'b1);
    bus.stall = 1'b1;
    @(negedge clk);
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h103;
    #1;
    checks++;
    if (flags() !== 6'b011010 || bus.branchVal !== 32'h100) begin
      errors++; $display("[TB] FAIL stall_redir: got %b/%h expected 011010/100", flags(), bus.branchVal);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if ({bus.imemReq, bus.pcEn} !== 2'b10) begin errors++; $display("[TB] FAIL stall_redir_next: got %b expected 10", {bus.imemReq, bus.pcEn}); end
    // Redirect and stall together on a completing fetch: redirect wins.
    bus.imemReady = 1'b1;
    bus.stall = 1'b1;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h204;
    #1;
    checks++;
    if (flags() !== 6'b111010 || bus.branchVal !== 32'h204) begin
      errors++; $display("[TB] FAIL req_redir_stall: got %b/%h expected 111010/204", flags(), bus.branchVal);
    end
    @(negedge clk);
    bus.redirectValid = 1'b0;
    #1;
    checks++;
    if (flags() !== 6'b100100) begin errors++; $display("[TB] FAIL req_redir_after: got %b expected 100100", flags()); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      checks++;
      if (bus.fetchErr !== 1'b0 || bus.imemReq !== 1'b1) begin
        errors++; $display("[TB] FAIL timeout_early[%0d]: got err=%b req=%b expected 0/1", i, bus.fetchErr, bus.imemReq);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (flags() !== 6'b000001 || bus.branchVal !== 32'h0) begin
      errors++; $display("[TB] FAIL timeout_err: got %b/%h expected 000001/0", flags(), bus.branchVal);
    end
    bus.imemReady = 1'b1;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h400;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (flags() !== 6'b000001) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 000001", flags()); end
    #1;
    pcRstN = 1'b0;
    #1;
    checks++;
    if (flags() !== 6'b0 || bus.branchVal !== 32'h0) begin
      errors++; $display("[TB] FAIL timeout_async_rst: got %b/%h expected 000000/0", flags(), bus.branchVal);
    end
  endtask

  task automatic test_random();
    int hold_left, wait_n;
    bit err, pend, stalled, take, rv, st, rdy;
    logic [31:0] pend_pc, bval, tgt, rpc, exp_bval;
    logic [5:0] exp_flags;
    @(negedge clk);
    pcRstN = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    pcRstN = 1'b1;
    hold_left = RST_HOLD; wait_n = 0; err = 0; pend = 0; stalled = 0;
    pend_pc = '0; bval = '0;
    for (int n = 0; n < 600; n++) begin
      rv  = ($urandom_range(0, 99) < 15);
      st  = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 60);
      rpc = $urandom;
      bus.redirectValid = rv; bus.stall = st; bus.imemReady = rdy; bus.redirectPc = rpc;
      #1;
      exp_flags = 6'b0; exp_bval = bval; tgt = '0; take = 0;
      if (err) begin
        exp_flags = 6'b000001; exp_bval = '0;
      end else if (hold_left > 0) begin
        exp_flags = 6'b0;
      end else if (stalled) begin
        if (rv) begin take = 1; tgt = rpc; end
        else exp_flags = {1'b0, !st, 1'b0, 1'b1, 2'b00};
      end else if (rdy && (rv || pend)) begin
        take = 1; tgt = rv ? rpc : pend_pc; exp_flags[5] = 1'b1;
      end else if (rdy) begin
        exp_flags = {1'b1, !st, 1'b0, 1'b1, 2'b00};
      end else begin
        exp_flags = 6'b100000;
      end
      if (take) begin
        exp_flags[4] = 1'b1; exp_flags[3] = 1'b1; exp_flags[1] = 1'b1;
        exp_bval = tgt & 32'hFFFF_FFFC;
      end
      checks++;
      if (flags() !== exp_flags || bus.branchVal !== exp_bval) begin
        errors++; $display("[TB] FAIL random[%0d]: got %b/%h expected %b/%h", n, flags(), bus.branchVal, exp_flags, exp_bval);
      end
      // Advance the model across the coming clock edge.
      if (!err) begin
        if (hold_left > 0) begin
          hold_left--;
          if (rv) begin pend = 1; pend_pc = rpc; end
        end else if (stalled) begin
          if (rv || !st) stalled = 0;
        end else if (rdy) begin
          wait_n = 0;
          if (rv || pend) pend = 0;
          else if (st) stalled = 1;
        end else begin
          wait_n++;
          if (wait_n == MAX_WAIT) err = 1;
          if (rv) begin pend = 1; pend_pc = rpc; end
        end
      end
      if (take) bval = exp_bval;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pcRstN = 1'b0;
    set_idle();
    test_reset();
    test_startup();
    test_wait_states();
    test_redirect_wait();
    test_stall();
    test_stall_redirect();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
